// File: rtl/physical_register_file_pkg.sv
// physical_register_file_pkg
//   Shared definitions for the physical register file and the execution
//   units that drive it.
//   - prf_idx_w    : register index width for a given register count
//   - PRF_ZERO_REG : hardwired zero register
//   - prf_rd_port_t / prf_wr_port_t : read/write port bundles at the default
//     PRF geometry (64 x 32)
//   Build option: PRF_WR_BYPASS_EN (consumed by physical_register_file and
//   prf_scoreboard) forwards same-cycle write data / ready to the readers.
package physical_register_file_pkg;

  function automatic int prf_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PRF_NUM_REGS_DEF = 64;
  localparam int PRF_DATA_W_DEF   = 32;
  localparam int PRF_IDX_W_DEF    = prf_idx_w(PRF_NUM_REGS_DEF);

  localparam int PRF_ZERO_REG = 0;

  typedef struct packed {
    logic [PRF_IDX_W_DEF-1:0] trgt;
  } prf_rd_port_t;

  typedef struct packed {
    logic [PRF_IDX_W_DEF-1:0]  trgt;
    logic [PRF_DATA_W_DEF-1:0] dat;
    logic                      we;
  } prf_wr_port_t;

endpackage

// File: rtl/physical_register_file_scoreboard.sv
// prf_scoreboard
//   Per-register ready bits. A valid write sets the bit, an allocation clears
//   it; allocation wins when both hit the same register in one cycle.
//   Register 0 is always ready and cannot be allocated.
//   Ports:
//     clk, rst                : clock, async active-high reset (all ready)
//     wr_trgt[1:0], wr_we[1:0]: write port targets / enables
//     alloc_en, alloc_trgt    : rename allocation
//     rdy[N-1:0]              : ready vector
//   Build option PRF_WR_BYPASS_EN: a register written this cycle reads ready
//   immediately unless it is also being allocated.
module prf_scoreboard
  import physical_register_file_pkg::*;
#(
  parameter int NUM_PHYSICAL_REGS = 64,
  localparam int IDX_W = prf_idx_w(NUM_PHYSICAL_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0][IDX_W-1:0]        wr_trgt,
  input  logic [1:0]                   wr_we,
  input  logic                         alloc_en,
  input  logic [IDX_W-1:0]             alloc_trgt,
  output logic [NUM_PHYSICAL_REGS-1:0] rdy
);

  logic [NUM_PHYSICAL_REGS-1:1] rdy_q;
  logic [NUM_PHYSICAL_REGS-1:1] wr_hit;
  logic [NUM_PHYSICAL_REGS-1:1] alloc_hit;

  // Register 0 is excluded up front so it can never hit either vector.
  always_comb begin
    wr_hit    = '0;
    alloc_hit = '0;
    for (int k = 0; k < 2; k++) begin
      if (wr_we[k] && (wr_trgt[k] != IDX_W'(PRF_ZERO_REG)))
        wr_hit[wr_trgt[k]] = 1'b1;
    end
    if (alloc_en && (alloc_trgt != IDX_W'(PRF_ZERO_REG)))
      alloc_hit[alloc_trgt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= '1;
    else     rdy_q <= (rdy_q | wr_hit) & ~alloc_hit;
  end

`ifdef PRF_WR_BYPASS_EN
  assign rdy = {rdy_q | (wr_hit & ~alloc_hit), 1'b1};
`else
  assign rdy = {rdy_q, 1'b1};
`endif

endmodule

// File: rtl/physical_register_file.sv
// physical_register_file
//   Physical register file with two combinational read ports, two clocked
//   write ports and a per-register ready scoreboard. Register 0 reads zero,
//   ignores writes and is always ready.
//   Ports:
//     clk, rst         : clock, async active-high reset (regs 0, all ready)
//     rd_trgt/rd_dat   : read targets / data (2 ports, combinational)
//     wr_trgt/wr_dat/wr_we : write triples (2 ports, port 1 wins collisions)
//     alloc_en/alloc_trgt  : rename allocation (clears ready)
//     rdy              : per-register ready vector
//   Build option PRF_WR_BYPASS_EN: reads matching an enabled same-cycle write
//   return the write data (port 1 preferred), and rdy is bypassed likewise.
module physical_register_file
  import physical_register_file_pkg::*;
#(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int DATA_W            = 32,
  localparam int IDX_W = prf_idx_w(NUM_PHYSICAL_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0][IDX_W-1:0]        rd_trgt,
  output logic [1:0][DATA_W-1:0]       rd_dat,
  input  logic [1:0][IDX_W-1:0]        wr_trgt,
  input  logic [1:0][DATA_W-1:0]       wr_dat,
  input  logic [1:0]                   wr_we,
  input  logic                         alloc_en,
  input  logic [IDX_W-1:0]             alloc_trgt,
  output logic [NUM_PHYSICAL_REGS-1:0] rdy
);

  // Register 0 has no storage at all.
  logic [DATA_W-1:0] regs [1:NUM_PHYSICAL_REGS-1];

  // Port 1 is written last so its non-blocking update wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_PHYSICAL_REGS; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_we[k] && (wr_trgt[k] != IDX_W'(PRF_ZERO_REG)))
          regs[wr_trgt[k]] <= wr_dat[k];
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < 2; k++) begin
      if (rd_trgt[k] != IDX_W'(PRF_ZERO_REG)) begin
        rd_dat[k] = regs[rd_trgt[k]];
`ifdef PRF_WR_BYPASS_EN
        for (int w = 0; w < 2; w++) begin
          if (wr_we[w] && (wr_trgt[w] == rd_trgt[k]))
            rd_dat[k] = wr_dat[w];
        end
`endif
      end
    end
  end

  prf_scoreboard #(
    .NUM_PHYSICAL_REGS(NUM_PHYSICAL_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_trgt   (wr_trgt),
    .wr_we     (wr_we),
    .alloc_en  (alloc_en),
    .alloc_trgt(alloc_trgt),
    .rdy       (rdy)
  );

endmodule

// File: tb/tb_physical_register_file.sv
module tb_physical_register_file;

  localparam int N  = 64;
  localparam int DW = 32;
  localparam int IW = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0][IW-1:0]  rd_trgt;
  logic [1:0][DW-1:0]  rd_dat;
  logic [1:0][IW-1:0]  wr_trgt;
  logic [1:0][DW-1:0]  wr_dat;
  logic [1:0]          wr_we;
  logic                alloc_en;
  logic [IW-1:0]       alloc_trgt;
  logic [N-1:0]        rdy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural contents and ready bits after the last edge.
  logic [DW-1:0] m_mem [N];
  logic [N-1:0]  m_rdy;

  physical_register_file #(.NUM_PHYSICAL_REGS(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_trgt   (rd_trgt),
    .rd_dat    (rd_dat),
    .wr_trgt   (wr_trgt),
    .wr_dat    (wr_dat),
    .wr_we     (wr_we),
    .alloc_en  (alloc_en),
    .alloc_trgt(alloc_trgt),
    .rdy       (rdy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_rdy = '1;
  endfunction

  // Value a reader should see this cycle for target t.
  function automatic logic [DW-1:0] exp_rd(input logic [IW-1:0] t);
    logic [DW-1:0] v;
    if (t == 0) return '0;
    v = m_mem[t];
`ifdef PRF_WR_BYPASS_EN
    if (wr_we[0] && wr_trgt[0] == t) v = wr_dat[0];
    if (wr_we[1] && wr_trgt[1] == t) v = wr_dat[1];
`endif
    return v;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] v;
    v = m_rdy;
`ifdef PRF_WR_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wr_we[k] && wr_trgt[k] != 0 && !(alloc_en && alloc_trgt == wr_trgt[k]))
        v[wr_trgt[k]] = 1'b1;
`endif
    v[0] = 1'b1;
    return v;
  endfunction

  // Advance one clock edge; the model commits the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        if (wr_we[k] && wr_trgt[k] != 0) begin
          m_mem[wr_trgt[k]] = wr_dat[k];
          m_rdy[wr_trgt[k]] = 1'b1;
        end
      if (alloc_en && alloc_trgt != 0) m_rdy[alloc_trgt] = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    wr_we    = '0;
    alloc_en = 1'b0;
  endtask

  task automatic test_reset();
    rd_trgt[0] = 6'd5;
    rd_trgt[1] = 6'd63;
    #2;
    n_cmp++;
    if (rd_dat[0] !== 32'h0) begin n_err++; $display("FAIL reset_rd0: got %h expected %h", rd_dat[0], 32'h0); end
    n_cmp++;
    if (rd_dat[1] !== 32'h0) begin n_err++; $display("FAIL reset_rd1: got %h expected %h", rd_dat[1], 32'h0); end
    n_cmp++;
    if (rdy !== {N{1'b1}}) begin n_err++; $display("FAIL reset_rdy: got %h expected all ones", rdy); end
  endtask

  task automatic test_basic_write();
    logic [DW-1:0] same_exp;
`ifdef PRF_WR_BYPASS_EN
    same_exp = 32'hDEADBEEF;
`else
    same_exp = 32'h0;
`endif
    wr_we = 2'b11;
    wr_trgt[0] = 6'd7;  wr_dat[0] = 32'hDEADBEEF;
    wr_trgt[1] = 6'd9;  wr_dat[1] = 32'h1;
    rd_trgt[0] = 6'd7;  rd_trgt[1] = 6'd9;
    #2;
    n_cmp++;
    if (rd_dat[0] !== same_exp) begin n_err++; $display("FAIL same_cycle_rd7: got %h expected %h", rd_dat[0], same_exp); end
    tick();
    idle();
    #2;
    n_cmp++;
    if (rd_dat[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd7: got %h expected %h", rd_dat[0], 32'hDEADBEEF); end
    n_cmp++;
    if (rd_dat[1] !== 32'h1) begin n_err++; $display("FAIL wr_rd9: got %h expected %h", rd_dat[1], 32'h1); end
  endtask

  task automatic test_collision();
    wr_we = 2'b11;
    wr_trgt[0] = 6'd12; wr_dat[0] = 32'hAAAA;
    wr_trgt[1] = 6'd12; wr_dat[1] = 32'h5555;
    rd_trgt[0] = 6'd12; rd_trgt[1] = 6'd12;
    tick();
    idle();
    #2;
    n_cmp++;
    if (rd_dat[0] !== 32'h5555) begin n_err++; $display("FAIL collision_rd12: got %h expected %h", rd_dat[0], 32'h5555); end
  endtask

  task automatic test_zero_reg();
    wr_we = 2'b01;
    wr_trgt[0] = 6'd0; wr_dat[0] = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_trgt = 6'd0;
    rd_trgt[0] = 6'd0;
    #2;
    n_cmp++;
    if (rd_dat[0] !== 32'h0) begin n_err++; $display("FAIL zero_same_cycle: got %h expected %h", rd_dat[0], 32'h0); end
    tick();
    idle();
    #2;
    n_cmp++;
    if (rd_dat[0] !== 32'h0) begin n_err++; $display("FAIL zero_rd: got %h expected %h", rd_dat[0], 32'h0); end
    n_cmp++;
    if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL zero_rdy: got %b expected 1", rdy[0]); end
  endtask

  task automatic test_alloc();
    logic same_rdy;
    alloc_en = 1'b1; alloc_trgt = 6'd20;
    tick();
    idle();
    #2;
    n_cmp++;
    if (rdy[20] !== 1'b0) begin n_err++; $display("FAIL alloc_rdy20: got %b expected 0", rdy[20]); end
    wr_we = 2'b01; wr_trgt[0] = 6'd20; wr_dat[0] = 32'hCAFE;
    alloc_en = 1'b1; alloc_trgt = 6'd20;
    #2;
    n_cmp++;
    if (rdy[20] !== 1'b0) begin n_err++; $display("FAIL wr_alloc_same_cycle_rdy20: got %b expected 0", rdy[20]); end
    tick();
    idle();
    rd_trgt[0] = 6'd20;
    #2;
    n_cmp++;
    if (rdy[20] !== 1'b0) begin n_err++; $display("FAIL wr_alloc_rdy20: got %b expected 0", rdy[20]); end
    n_cmp++;
    if (rd_dat[0] !== 32'hCAFE) begin n_err++; $display("FAIL wr_alloc_data20: got %h expected %h", rd_dat[0], 32'hCAFE); end
`ifdef PRF_WR_BYPASS_EN
    same_rdy = 1'b1;
`else
    same_rdy = 1'b0;
`endif
    wr_we = 2'b10; wr_trgt[1] = 6'd20; wr_dat[1] = 32'hBEEF;
    #2;
    n_cmp++;
    if (rdy[20] !== same_rdy) begin n_err++; $display("FAIL wr_same_cycle_rdy20: got %b expected %b", rdy[20], same_rdy); end
    tick();
    idle();
    #2;
    n_cmp++;
    if (rdy[20] !== 1'b1) begin n_err++; $display("FAIL wr_rdy20: got %b expected 1", rdy[20]); end
    n_cmp++;
    if (rd_dat[0] !== 32'hBEEF) begin n_err++; $display("FAIL wr_data20: got %h expected %h", rd_dat[0], 32'hBEEF); end
  endtask

  task automatic test_async_reset();
    wr_we = 2'b01; wr_trgt[0] = 6'd3; wr_dat[0] = 32'h1234;
    alloc_en = 1'b1; alloc_trgt = 6'd30;
    tick();
    idle();
    rd_trgt[0] = 6'd3;
    #2;
    n_cmp++;
    if (rd_dat[0] !== 32'h1234) begin n_err++; $display("FAIL pre_rst_rd3: got %h expected %h", rd_dat[0], 32'h1234); end
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (rd_dat[0] !== 32'h0) begin n_err++; $display("FAIL async_rst_rd3: got %h expected %h", rd_dat[0], 32'h0); end
    n_cmp++;
    if (rdy !== {N{1'b1}}) begin n_err++; $display("FAIL async_rst_rdy: got %h expected all ones", rdy); end
    // Write and alloc held through an edge while in reset must be lost.
    wr_we = 2'b01; wr_trgt[0] = 6'd3; wr_dat[0] = 32'h9999;
    alloc_en = 1'b1; alloc_trgt = 6'd3;
    tick();
    n_cmp++;
    if (rd_dat[0] !== 32'h0) begin n_err++; $display("FAIL in_rst_write_rd3: got %h expected %h", rd_dat[0], 32'h0); end
    n_cmp++;
    if (rdy[3] !== 1'b1) begin n_err++; $display("FAIL in_rst_alloc_rdy3: got %b expected 1", rdy[3]); end
    idle();
    #2;
    rst = 1'b0;
    #1;
    wr_we = 2'b01; wr_trgt[0] = 6'd4; wr_dat[0] = 32'h77;
    rd_trgt[1] = 6'd4;
    tick();
    idle();
    #2;
    n_cmp++;
    if (rd_dat[1] !== 32'h77) begin n_err++; $display("FAIL post_rst_write_rd4: got %h expected %h", rd_dat[1], 32'h77); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e0, e1;
    logic [N-1:0]  er;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        // Small-range targets half the time to provoke collisions.
        wr_trgt[k] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        rd_trgt[k] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        wr_dat[k]  = $urandom;
        wr_we[k]   = ($urandom_range(0, 3) != 0);
      end
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_trgt = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      #2;
      e0 = exp_rd(rd_trgt[0]);
      e1 = exp_rd(rd_trgt[1]);
      er = exp_rdy();
      n_cmp++;
      if (rd_dat[0] !== e0) begin n_err++; $display("FAIL rand_rd0 cyc %0d: got %h expected %h", c, rd_dat[0], e0); end
      n_cmp++;
      if (rd_dat[1] !== e1) begin n_err++; $display("FAIL rand_rd1 cyc %0d: got %h expected %h", c, rd_dat[1], e1); end
      n_cmp++;
      if (rdy !== er) begin n_err++; $display("FAIL rand_rdy cyc %0d: got %h expected %h", c, rdy, er); end
      tick();
    end
    idle();
  endtask

  initial begin
    rst        = 1'b1;
    rd_trgt    = '0;
    wr_trgt    = '0;
    wr_dat     = '0;
    wr_we      = '0;
    alloc_en   = 1'b0;
    alloc_trgt = '0;
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    @(posedge clk);
    #1;
    test_basic_write();
    test_collision();
    test_zero_reg();
    test_alloc();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
